// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and slave address-window geometry.
// Also used by the fabric address decoder so both agree on SLAVE_ADDR_BITS.
package apb_pkg;
    typedef enum logic {
        APB_IDLE,
        APB_ACCESS
    } apb_state_e;

    localparam int SLAVE_ADDR_BITS = 16;
    localparam int BYTE_W          = 8;
    localparam int IDX_W           = SLAVE_ADDR_BITS - 2;
endpackage

// File: rtl/apb_slave_regs_if.sv
// APB4 bus bundle for one slave port; master drives the request, slave the response.
// psel here is the single psel_slaves bit routed to this slave.
interface apb_slave_regs_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_regs_fsm.sv
// APB transfer sequencer: latches request at setup, counts wait states, flags completion.
// Completion 1+WAIT_STATES cycles after setup; pready held low while waits remain.
module apb_slave_fsm
    import apb_pkg::*;
#(
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                       pclk,
    input  logic                       preset,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [SLAVE_ADDR_BITS-1:0] addr,
    output logic                       pready,
    output logic                       commit,
    output logic                       abort,
    output logic                       pwrite_q,
    output logic [IDX_W-1:0]           idx_q,
    output logic                       err_q
);
    localparam logic [IDX_W:0]   NUM_REGS_W = (IDX_W + 1)'(NUM_REGS);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REGS - 1);
    localparam logic [3:0]       WAIT_INIT  = 4'(WAIT_STATES);

    apb_state_e       state_q, state_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic             pwrite_d, err_d;
    logic [IDX_W-1:0] idx_d;
    logic [IDX_W-1:0] idx_in;
    logic             err_in;

    assign idx_in = addr[SLAVE_ADDR_BITS-1:2];
    // Writes to the last slot hit the read-only counter and are rejected.
    assign err_in = (addr[1:0] != 2'b00) || ({1'b0, idx_in} >= NUM_REGS_W)
                  || (pwrite && (idx_in == LAST_IDX));

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        pwrite_d = pwrite_q;
        idx_d    = idx_q;
        err_d    = err_q;
        commit   = 1'b0;
        abort    = 1'b0;
        pready   = (state_q == APB_ACCESS) && (wcnt_q == 4'd0);
        case (state_q)
            APB_IDLE: begin
                if (psel && !penable) begin
                    pwrite_d = pwrite;
                    idx_d    = idx_in;
                    err_d    = err_in;
                    wcnt_d   = WAIT_INIT;
                    state_d  = APB_ACCESS;
                end
            end
            APB_ACCESS: begin
                if (!psel) begin
                    abort   = 1'b1;
                    state_d = APB_IDLE;
                end else if (penable) begin
                    if (wcnt_q != 4'd0) begin
                        wcnt_d = wcnt_q - 4'd1;
                    end else begin
                        commit  = pwrite_q && !err_q;
                        state_d = APB_IDLE;
                    end
                end
            end
            default: state_d = APB_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q  <= APB_IDLE;
            wcnt_q   <= 4'd0;
            pwrite_q <= 1'b0;
            idx_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            pwrite_q <= pwrite_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: rtl/apb_slave_regs.sv
// APB4 register slave: NUM_REGS-1 byte-strobed RW registers plus a RO committed-write counter.
// Transfer completes 1+WAIT_STATES cycles after setup; errors reported via pslverr.
module apb_slave_regs
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                  pclk,
    input  logic                  preset,
    apb_slave_regs_if.slave       bus,
    output logic [DATA_WIDTH-1:0] ctrl_out
);
    localparam int NB = DATA_WIDTH / BYTE_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS-1];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS-1];
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rd_dat;
    logic                  pready, commit, abort, pwrite_q, err_q, wr_en;
    logic [IDX_W-1:0]      idx_q;
    logic                  unused_addr_hi;

    // Upper address bits belong to the fabric decoder.
    assign unused_addr_hi = ^bus.paddr[ADDR_WIDTH-1:SLAVE_ADDR_BITS];

    apb_slave_fsm #(
        .NUM_REGS    (NUM_REGS),
        .WAIT_STATES (WAIT_STATES)
    ) u_fsm (
        .pclk     (pclk),
        .preset   (preset),
        .psel     (bus.psel),
        .penable  (bus.penable),
        .pwrite   (bus.pwrite),
        .addr     (bus.paddr[SLAVE_ADDR_BITS-1:0]),
        .pready   (pready),
        .commit   (commit),
        .abort    (abort),
        .pwrite_q (pwrite_q),
        .idx_q    (idx_q),
        .err_q    (err_q)
    );

    assign wr_en = commit && !abort;

    always_comb begin
        cnt_d  = cnt_q;
        rd_dat = '0;
        if (idx_q == LAST_IDX) rd_dat = cnt_q;
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            regs_d[i] = regs_q[i];
            if (idx_q == IDX_W'(i)) begin
                rd_dat = regs_q[i];
                if (wr_en) begin
                    for (int b = 0; b < NB; b++) begin
                        if (bus.pstrb[b]) regs_d[i][b*BYTE_W +: BYTE_W] = bus.pwdata[b*BYTE_W +: BYTE_W];
                    end
                end
            end
        end
        // A zero-strobe write is still a committed write and is counted.
        if (wr_en) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int i = 0; i < NUM_REGS - 1; i++) regs_q[i] <= '0;
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS - 1; i++) regs_q[i] <= regs_d[i];
            cnt_q <= cnt_d;
        end
    end

    assign bus.pready  = pready;
    assign bus.pslverr = pready && err_q;
    assign bus.prdata  = (pready && !pwrite_q && !err_q) ? rd_dat : '0;
    assign ctrl_out    = regs_q[0];
endmodule

// File: doc/apb_slave_regs.md
Name: apb_slave_regs

Overview:
- APB4 responder (completer) on one slave port of the multi-slave APB fabric, selected by one psel_slaves bit from the address decoder.
- Holds NUM_REGS 32-bit registers.
  - Registers 0..NUM_REGS-2 are read/write with byte strobes.
  - Register NUM_REGS-1 is a read-only write-transaction counter.
- Inserts WAIT_STATES programmable wait states per transfer.
- Flags PSLVERR on bad accesses.

Parameters:
- ADDR_WIDTH, 32, width of paddr.
- DATA_WIDTH, 32, width of pwdata/prdata; fixed at 32 for this block.
- NUM_REGS, 8, total register count including the RO counter; must be 2..16384 (64KB window).
- WAIT_STATES, 0, extra ACCESS cycles with pready low before completion; 0..15.

Ports:
- pclk  input  1  APB clock; all logic is rising-edge.
- preset  input  1  synchronous, active-high reset.
- psel  input  1  slave select from the decoder.
- penable  input  1  APB access-phase indicator.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  ADDR_WIDTH  byte address; only paddr[15:0] is decoded.
- pwdata  input  DATA_WIDTH  write data.
- pstrb  input  DATA_WIDTH/8  write byte strobes.
- prdata  output  DATA_WIDTH  read data.
- pready  output  1  transfer completion.
- pslverr  output  1  transfer error, valid only when pready=1.
- ctrl_out  output  DATA_WIDTH  live value of register 0, for the attached peripheral.

Behaviour:
- Clock/reset: one clock, pclk. Reset preset is synchronous and active-high. Sampled on the pclk edge, it forces:
  - FSM to IDLE.
  - All RW registers to 0, counter to 0.
  - pready=0, pslverr=0, prdata=0.
- Reset mid-transfer: the pending write is discarded; no completion is signalled.
- Address decode:
  - idx = paddr[15:2].
  - Error condition err = (paddr[1:0]!=0) OR (idx>=NUM_REGS) OR (pwrite AND idx==NUM_REGS-1).
  - err is evaluated on the setup cycle and held in a register.
  - paddr[ADDR_WIDTH-1:16] is ignored; it belongs to the decoder.
- FSM states: IDLE, ACCESS.
  - IDLE: when psel=1 and penable=0 (setup phase), latch pwrite/idx/err, load wcnt=WAIT_STATES, go to ACCESS. All other inputs are ignored.
  - ACCESS with psel=0: the transfer is aborted; go to IDLE, no register update, no count.
  - ACCESS with psel=1, penable=1, wcnt!=0: decrement wcnt; pready=0.
  - ACCESS with psel=1, penable=1, wcnt==0: completion cycle; go to IDLE on this edge.
- pready, pslverr and prdata are combinational from state/wcnt/latched info:
  - pready = (state==ACCESS AND wcnt==0).
  - pslverr = pready AND err_q.
  - prdata = register[idx_q] when pready AND NOT pwrite_q AND NOT err_q; otherwise 0.
- Latency: completion is 1+WAIT_STATES cycles after the setup cycle. WAIT_STATES=0 gives a zero-wait 2-cycle APB transfer.
- Write commit happens on the completion edge only, and only if NOT err_q.
  - Byte lane b of register[idx_q] is updated with pwdata[8b+7:8b] only where pstrb[b]=1.
  - pstrb=0 is a legal write: no data change, but still counted.
- Counter: increments by 1 on every committed (error-free) write; wraps from 0xFFFFFFFF to 0. Errored and aborted writes are not counted.
- Back-to-back transfers: a new setup cycle is accepted on the cycle immediately after completion (FSM is in IDLE). No idle cycle is required.
- paddr/pwrite changes during ACCESS are ignored; values are latched at setup.
- Reads never have side effects.

Decomposition:
- Shared package apb_pkg holds:
  - FSM state enum (APB_IDLE, APB_ACCESS).
  - localparam SLAVE_ADDR_BITS=16.
  - Byte-lane width constant.
- The decoder uses the same SLAVE_ADDR_BITS.
- One natural sub-module: apb_slave_fsm, owning the state, wait counter and latched pwrite/idx/err, with outputs pready/commit/abort. apb_slave_regs holds the register array, strobe merge, counter and read mux.

Test Plan:
- WAIT_STATES=0: write 0xDEADBEEF to 0x0, pstrb=0xF, then read 0x0. Each transfer completes with pready on its 2nd cycle; prdata=0xDEADBEEF, pslverr=0; ctrl_out=0xDEADBEEF; counter (0x1C) reads 1.
- Byte strobes: reg1=0x11223344, write 0xAABBCCDD with pstrb=0x5 -> reg1 reads 0x11BB33DD; counter increments.
- Errors, each expected to give pslverr=1 with pready, no register or counter change, prdata=0:
  - write to 0x1C (RO counter);
  - read 0x20 (out of range);
  - write 0x6 (misaligned).
- WAIT_STATES=3: read 0x4. pready low for 3 ACCESS cycles, high on the 4th; back-to-back write accepted on the very next cycle.
- Abort and reset:
  - psel dropped in ACCESS during a write with WAIT_STATES=2 -> FSM to IDLE, no update, counter unchanged.
  - preset asserted mid-ACCESS -> next cycle pready=0 and all registers 0.
